regfile_writeback: RTL and testbench

//  Write-port driver for the RISC-V register bank: owns ptr_wr/data_wr/wr_en.

---
 rtl/regfile_writeback.sv | 104 ++++++++++
 tb/tb_regfile_writeback.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register bank write-port driver merging ALU and load results
// Keeps a pending-load scoreboard that decode uses for RAW hazard stalls.
module regfile_writeback #(
  parameter int N     = 32,
  parameter int Bits  = 64,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [$clog2(N)-1:0] alu_rd,
  input  logic [Bits-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [$clog2(N)-1:0] ld_rd,
  input  logic [Bits-1:0]      ld_data,
  input  logic                 pend_set,
  input  logic [$clog2(N)-1:0] pend_rd,
  output logic [N-1:0]         pending,
  output logic [$clog2(N)-1:0] ptr_wr,
  output logic [Bits-1:0]      data_wr,
  output logic                 wr_en
);
  localparam int PW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]   rd_mem   [DEPTH];
  logic [Bits-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic fifo_empty, alu_win, ld_live, fifo_pop, bypass, push;
  logic [PW-1:0]   commit_rd;
  logic [N-1:0]    set_mask, clr_mask;

  // Ready is held low while reset is asserted even though count is already zero.
  assign ld_ready   = rst && (count < CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign alu_win    = alu_valid && (alu_rd != '0);
  assign ld_live    = ld_valid && ld_ready && (ld_rd != '0);
  assign fifo_pop   = !alu_win && !fifo_empty;
  assign bypass     = !alu_win && fifo_empty && ld_live;
  assign push       = ld_live && !bypass;
  assign commit_rd  = fifo_pop ? rd_mem[rd_ptr] : ld_rd;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pend_set && (pend_rd != '0))
      set_mask[pend_rd] = 1'b1;
    if (fifo_pop || bypass)
      clr_mask[commit_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ld_rd;
      data_mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      ptr_wr  <= '0;
      data_wr <= '0;
      pending <= '0;
    end else begin
      wr_en <= alu_win || fifo_pop || bypass;
      if (alu_win) begin
        ptr_wr  <= alu_rd;
        data_wr <= alu_data;
      end else if (fifo_pop) begin
        ptr_wr  <= rd_mem[rd_ptr];
        data_wr <= data_mem[rd_ptr];
      end else if (bypass) begin
        ptr_wr  <= ld_rd;
        data_wr <= ld_data;
      end
      // A new issue to the same register outranks the commit of the older load.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic [31:0] pending;
  logic [4:0]  ptr_wr;
  logic [63:0] data_wr;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.N(32), .Bits(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .pend_set(pend_set), .pend_rd(pend_rd), .pending(pending),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    pend_set = 1'b0; pend_rd = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_ptr", ptr_wr, 0);
    check("rst_data", data_wr, 0);
    check("rst_pending", pending, 0);
    check("rst_ld_ready", ld_ready, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("post_rst_ld_ready", ld_ready, 1);

    // ALU path, then rd=0 ignored with outputs holding
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hABCD;
    step();
    check("alu_wr_en", wr_en, 1);
    check("alu_ptr", ptr_wr, 5);
    check("alu_data", data_wr, 64'hABCD);
    alu_rd = 5'd0; alu_data = 64'h1234;
    step();
    check("alu_x0_wr_en", wr_en, 0);
    check("alu_x0_ptr_hold", ptr_wr, 5);
    check("alu_x0_data_hold", data_wr, 64'hABCD);
    idle();

    // Load bypass clears its pending bit on the write edge
    pend_set = 1'b1; pend_rd = 5'd7;
    step();
    check("pend7_set", pending, 32'h80);
    idle();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h11;
    step();
    check("byp_wr_en", wr_en, 1);
    check("byp_ptr", ptr_wr, 7);
    check("byp_data", data_wr, 64'h11);
    check("byp_pending_clr", pending, 0);
    idle();

    // ALU and load in the same cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h44;
    step();
    check("conf_ptr1", ptr_wr, 3);
    check("conf_data1", data_wr, 64'h33);
    check("conf_count", dut.count, 1);
    idle();
    step();
    check("conf_wr_en2", wr_en, 1);
    check("conf_ptr2", ptr_wr, 4);
    check("conf_data2", data_wr, 64'h44);
    check("conf_count_drained", dut.count, 0);
    step();
    check("conf_idle", wr_en, 0);

    // Backpressure: ALU holds the port for six cycles
    begin
      int li = 0;
      for (int k = 0; k < 6; k++) begin
        check($sformatf("bp_ready_%0d", k), ld_ready, (k < 4) ? 1 : 0);
        alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 64'hA0 + 64'(k);
        ld_valid = 1'b1; ld_rd = 5'(11 + li); ld_data = 64'h100 + 64'(li);
        if (ld_ready) li++;
        step();
        check($sformatf("bp_alu_ptr_%0d", k), ptr_wr, 20 + k);
      end
      check("bp_ready_full", ld_ready, 0);
      idle();
      for (int j = 0; j < 4; j++) begin
        step();
        check($sformatf("drain_wr_en_%0d", j), wr_en, 1);
        check($sformatf("drain_ptr_%0d", j), ptr_wr, 11 + j);
        check($sformatf("drain_data_%0d", j), data_wr, 64'h100 + 64'(j));
      end
      step();
      check("drain_done", wr_en, 0);
      check("drain_ready", ld_ready, 1);
    end

    // Scoreboard: re-issue in the commit cycle keeps the bit set
    pend_set = 1'b1; pend_rd = 5'd9;
    step();
    check("sb_set", pending, 32'h200);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99;
    step();
    check("sb_commit1_ptr", ptr_wr, 9);
    check("sb_set_wins", pending, 32'h200);
    idle();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h98;
    step();
    check("sb_commit2_data", data_wr, 64'h98);
    check("sb_cleared", pending, 0);
    idle();

    // Async reset with three queued loads
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h5;
      ld_valid = 1'b1; ld_rd = 5'(12 + k); ld_data = 64'h200 + 64'(k);
      pend_set = (k == 0); pend_rd = 5'd12;
      step();
    end
    idle();
    check("ar_count", dut.count, 3);
    check("ar_pending", pending, 32'h1000);
    check("ar_wr_en_before", wr_en, 1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_wr_en", wr_en, 0);
    check("ar_ptr", ptr_wr, 0);
    check("ar_data", data_wr, 0);
    check("ar_pending_clr", pending, 0);
    check("ar_ld_ready", ld_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    check("ar_ready_release", ld_ready, 1);
    step();
    check("ar_no_stale1", wr_en, 0);
    step();
    check("ar_no_stale2", wr_en, 0);
    check("ar_count_zero", dut.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
